// File: rtl/ground_pkg.sv
// Shared constants and helpers for the scrolling ground strip: tile contents,
// below-tile fill colour and a constant-evaluable log2.
package ground_pkg;

    localparam logic [11:0] FILL_RGB = 12'he51;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Tile contents as {r4,g4,b4}: red follows the column, green the row,
    // blue a checker of both, so every texel in a 16x16 tile is distinct.
    function automatic logic [11:0] tile_rom(input logic [5:0] row, input logic [5:0] col);
        logic [3:0] r4;
        logic [3:0] g4;
        logic [3:0] b4;
        r4 = col[3:0];
        g4 = row[3:0];
        b4 = col[3:0] ^ row[3:0] ^ 4'h5;
        return {r4, g4, b4};
    endfunction

endpackage

// File: rtl/ground_tile_rom.sv
// Synchronous-read tile ROM: one-cycle latency, data register has no reset.
module ground_tile_rom
    import ground_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic                     clk,
    input  logic [ROW_W+COL_W-1:0]   i_addr,
    output logic [11:0]              o_data
);

    logic [5:0] w_row;
    logic [5:0] w_col;

    assign w_row = 6'(i_addr[ROW_W+COL_W-1:COL_W]);
    assign w_col = 6'(i_addr[COL_W-1:0]);

    always_ff @(posedge clk) begin
        o_data <= tile_rom(w_row, w_col);
    end

endmodule

// File: rtl/scroll_ground_strip.sv
// Horizontally scrolling ground band: per-frame scroll register, then a
// two-stage pixel path (ROM lookup + flags, then colour mux).
module scroll_ground_strip
    import ground_pkg::*;
#(
    parameter int TILE_W   = 16,
    parameter int TILE_H   = 16,
    parameter int GROUND_Y = 400,
    parameter int SCREEN_H = 480,
    parameter int SPEED_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [10:0]                ix,
    input  logic [10:0]                iy,
    input  logic                       in_valid,
    input  logic                       frame_tick,
    input  logic                       run,
    input  logic [SPEED_W-1:0]         speed,
    output logic [7:0]                 oR,
    output logic [7:0]                 oG,
    output logic [7:0]                 oB,
    output logic                       mask,
    output logic                       out_valid,
    output logic [clog2(TILE_W)-1:0]   scroll_x
);

    localparam int COL_W = clog2(TILE_W);
    localparam int ROW_W = clog2(TILE_H);
    localparam logic [10:0] C_GROUND_Y = 11'(GROUND_Y);
    localparam logic [10:0] C_SCREEN_H = 11'(SCREEN_H);
    localparam logic [10:0] C_TILE_H   = 11'(TILE_H);

    logic [COL_W-1:0]       r_scroll;
    logic [COL_W-1:0]       w_step;
    logic [COL_W-1:0]       w_col;
    logic [10:0]            w_row_full;
    logic [ROW_W-1:0]       w_row;
    logic                   w_hit;
    logic                   w_band;
    logic [11:0]            w_rom_data;
    logic [11:0]            w_rgb;

    logic                   r_s1_valid;
    logic                   r_s1_band;
    logic                   r_s1_hit;
    logic [7:0]             r_r;
    logic [7:0]             r_g;
    logic [7:0]             r_b;
    logic                   r_mask;
    logic                   r_valid;

    // Steps of TILE_W or more would alias to small steps, so clamp to TILE_W-1.
    always_comb begin
        w_step = COL_W'(speed);
        if (32'(speed) > TILE_W - 1) w_step = COL_W'(TILE_W - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scroll <= '0;
        else if (frame_tick && run) r_scroll <= r_scroll + w_step;
    end

    assign w_band     = in_valid && (iy >= C_GROUND_Y) && (iy < C_SCREEN_H);
    assign w_col      = COL_W'(ix + 11'(r_scroll));
    assign w_row_full = iy - C_GROUND_Y;
    assign w_hit      = w_row_full < C_TILE_H;
    // Rows below the tile reuse the last tile row; the fill colour replaces it later.
    assign w_row      = w_hit ? w_row_full[ROW_W-1:0] : ROW_W'(TILE_H - 1);

    ground_tile_rom #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_rom (
        .clk    (clk),
        .i_addr ({w_row, w_col}),
        .o_data (w_rom_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_band  <= 1'b0;
            r_s1_hit   <= 1'b0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_band  <= w_band;
            r_s1_hit   <= w_hit;
        end
    end

    assign w_rgb = r_s1_hit ? w_rom_data : FILL_RGB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_mask  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_s1_valid;
            r_mask  <= r_s1_band;
            if (r_s1_band) begin
                r_r <= {w_rgb[11:8], 4'b0000};
                r_g <= {w_rgb[7:4],  4'b0000};
                r_b <= {w_rgb[3:0],  4'b0000};
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign oR        = r_r;
    assign oG        = r_g;
    assign oB        = r_b;
    assign mask      = r_mask;
    assign out_valid = r_valid;
    assign scroll_x  = r_scroll;

endmodule
